// File: rtl/freq_ramp_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : freq_ramp_ctrl_if
//  Purpose  : Bundles the host command port, the host break level and the
//             go_reconfig / reqstd_frequency handshake with the hash-clock
//             reconfiguration stage, together with the status outputs.
//  Modports : master - the ramp controller (drives command ready, request,
//                      applied code and status flags)
//             slave  - the surrounding logic (host side + reconfiguration
//                      stage)
//  Revision : 1.0 - initial release
// ============================================================================
interface freq_ramp_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_freq;
  logic       cmd_ready;
  logic       host_break;
  logic       busy;
  logic       reconfig_ok;
  logic       go_reconfig;
  logic [7:0] reqstd_frequency;
  logic [7:0] cur_freq;
  logic       ramp_active;
  logic       err_range;
  logic       err_timeout;

  modport master (
    input  cmd_valid, cmd_freq, host_break, busy, reconfig_ok,
    output cmd_ready, go_reconfig, reqstd_frequency, cur_freq,
           ramp_active, err_range, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_freq, host_break, busy, reconfig_ok,
    input  cmd_ready, go_reconfig, reqstd_frequency, cur_freq,
           ramp_active, err_range, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/freq_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : freq_ramp_ctrl
//  Purpose  : Accepts host frequency codes (1..MAX_CODE) and walks the SHA
//             PLL toward the target in steps of at most STEP codes, one
//             reconfiguration request per step, with confirmation, settle
//             dwell, timeout and bounded retry.
//  Ports    : clk    - 25 MHz clock shared with the reconfiguration stage
//             areset - asynchronous active-high reset
//             bus    - freq_ramp_ctrl_if.master (command, break, handshake
//                      and status signals)
//  Options  : FREQ_DOWN_DIRECT_EN - when defined, descents jump straight to
//             the target in a single step; ascents still use STEP.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_ramp_ctrl #(
  parameter int MAX_CODE    = 96,
  parameter int STEP        = 4,
  parameter int SETTLE_CYC  = 25000,
  parameter int TIMEOUT_CYC = 250000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             areset,
  freq_ramp_ctrl_if.master bus
);

  localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
  localparam int c_stl_w = $clog2(SETTLE_CYC + 1);
  localparam int c_rty_w = $clog2(MAX_RETRY + 1);

  localparam logic [c_tmo_w-1:0]  c_tmo_load  = c_tmo_w'(TIMEOUT_CYC - 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_one   = c_tmo_w'(1);
  localparam logic [c_stl_w-1:0]  c_stl_load  = c_stl_w'(SETTLE_CYC - 1);
  localparam logic [c_stl_w-1:0]  c_stl_one   = c_stl_w'(1);
  localparam logic [c_rty_w-1:0]  c_max_retry = c_rty_w'(MAX_RETRY);
  localparam logic [c_rty_w-1:0]  c_rty_one   = c_rty_w'(1);
  localparam logic [7:0]          c_max_code  = 8'(MAX_CODE);
  localparam logic signed [8:0]   c_step      = 9'(STEP);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CALC      = 4'd1,
    S_REQ       = 4'd2,
    S_WAIT_ACK  = 4'd3,
    S_WAIT_OK   = 4'd4,
    S_WAIT_IDLE = 4'd5,
    S_SETTLE    = 4'd6,
    S_TMO_DRAIN = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  state_t              r_state, w_state;
  logic                r_go, w_go;
  logic [7:0]          r_req, w_req;
  logic [7:0]          r_cur, w_cur;
  logic [7:0]          r_target, w_target;
  logic                r_err_range, w_err_range;
  logic                r_err_tmo, w_err_tmo;
  logic [c_tmo_w-1:0]  r_tmo_cnt, w_tmo_cnt;
  logic [c_stl_w-1:0]  r_stl_cnt, w_stl_cnt;
  logic [c_rty_w-1:0]  r_retry, w_retry;
  logic                r_break_d;

  logic                w_break_edge;
  logic                w_cmd_ready;
  logic                w_cmd_take;
  logic                w_cmd_legal;
  logic                w_tmo_expired;
  logic [7:0]          w_next;
  logic signed [8:0]   w_cur_s, w_tgt_s, w_up, w_next_s;

  // A held break level only counts on its first cycle.
  assign w_break_edge  = bus.host_break & ~r_break_d;
  assign w_cmd_ready   = (r_state == S_IDLE) || (r_state == S_SETTLE) ||
                         (r_state == S_ERROR);
  // A break edge in the same cycle drops the command silently.
  assign w_cmd_take    = bus.cmd_valid & w_cmd_ready & ~w_break_edge;
  assign w_cmd_legal   = (bus.cmd_freq != 8'd0) && (bus.cmd_freq <= c_max_code);
  assign w_tmo_expired = (r_tmo_cnt == '0);

  // Next step code, computed 9-bit signed so cur +/- STEP cannot wrap.
  assign w_cur_s = signed'({1'b0, r_cur});
  assign w_tgt_s = signed'({1'b0, r_target});
  assign w_up    = w_cur_s + c_step;

`ifdef FREQ_DOWN_DIRECT_EN
  always_comb begin
    w_next_s = w_tgt_s;
    if (w_tgt_s > w_cur_s) w_next_s = (w_up > w_tgt_s) ? w_tgt_s : w_up;
  end
`else
  logic signed [8:0] w_dn;
  assign w_dn = w_cur_s - c_step;

  always_comb begin
    w_next_s = (w_dn < w_tgt_s) ? w_tgt_s : w_dn;
    if (w_tgt_s > w_cur_s) w_next_s = (w_up > w_tgt_s) ? w_tgt_s : w_up;
  end
`endif

  assign w_next = 8'(w_next_s);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_go        <= 1'b0;
      r_req       <= 8'd1;
      r_cur       <= 8'd1;
      r_target    <= 8'd1;
      r_err_range <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_stl_cnt   <= '0;
      r_retry     <= '0;
      r_break_d   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_go        <= w_go;
      r_req       <= w_req;
      r_cur       <= w_cur;
      r_target    <= w_target;
      r_err_range <= w_err_range;
      r_err_tmo   <= w_err_tmo;
      r_tmo_cnt   <= w_tmo_cnt;
      r_stl_cnt   <= w_stl_cnt;
      r_retry     <= w_retry;
      r_break_d   <= bus.host_break;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_go        = r_go;
    w_req       = r_req;
    w_cur       = r_cur;
    w_target    = r_target;
    w_err_range = 1'b0;
    w_err_tmo   = r_err_tmo;
    w_tmo_cnt   = r_tmo_cnt;
    w_stl_cnt   = r_stl_cnt;
    w_retry     = r_retry;

    // Target updates are independent of the step sequencing below.
    if (w_break_edge) begin
      w_target = 8'd1;
    end else if (w_cmd_take) begin
      if (w_cmd_legal) begin
        w_target  = bus.cmd_freq;
        w_err_tmo = 1'b0;
      end else begin
        w_err_range = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (r_target != r_cur) w_state = S_CALC;
      end
      S_CALC: begin
        w_req   = w_next;
        w_retry = '0;
        w_state = S_REQ;
      end
      S_REQ: begin
        w_go      = 1'b1;
        w_tmo_cnt = c_tmo_load;
        w_state   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.busy && bus.reconfig_ok) begin
          w_go    = 1'b0;
          w_cur   = r_req;
          w_state = S_WAIT_IDLE;
        end else if (bus.busy) begin
          w_go    = 1'b0;
          w_state = S_WAIT_OK;
          if (!w_tmo_expired) w_tmo_cnt = r_tmo_cnt - c_tmo_one;
        end else if (w_tmo_expired) begin
          w_go    = 1'b0;
          w_state = S_TMO_DRAIN;
        end else begin
          w_tmo_cnt = r_tmo_cnt - c_tmo_one;
        end
      end
      S_WAIT_OK: begin
        // Confirmation takes priority over an expiry in the same cycle.
        if (bus.reconfig_ok) begin
          w_cur   = r_req;
          w_state = S_WAIT_IDLE;
        end else if (w_tmo_expired) begin
          w_state = S_TMO_DRAIN;
        end else begin
          w_tmo_cnt = r_tmo_cnt - c_tmo_one;
        end
      end
      S_WAIT_IDLE: begin
        if (!bus.busy) begin
          w_stl_cnt = c_stl_load;
          w_state   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_stl_cnt == '0) w_state = S_IDLE;
        else                 w_stl_cnt = r_stl_cnt - c_stl_one;
      end
      S_TMO_DRAIN: begin
        // Let the stage go idle before re-requesting the same code.
        if (!bus.busy) begin
          if (r_retry < c_max_retry) begin
            w_retry = r_retry + c_rty_one;
            w_state = S_REQ;
          end else begin
            w_err_tmo = 1'b1;
            w_state   = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        w_go = 1'b0;
        if (w_break_edge) begin
          w_err_tmo = 1'b0;
          w_state   = S_IDLE;
        end else if (w_cmd_take && w_cmd_legal) begin
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.cmd_ready        = w_cmd_ready;
  assign bus.go_reconfig      = r_go;
  assign bus.reqstd_frequency = r_req;
  assign bus.cur_freq         = r_cur;
  assign bus.err_range        = r_err_range;
  assign bus.err_timeout      = r_err_tmo;
  assign bus.ramp_active      = (r_target != r_cur) ||
                                ((r_state != S_IDLE) && (r_state != S_ERROR));

endmodule
`default_nettype wire

// File: doc/freq_ramp_ctrl.md
Name: freq_ramp_ctrl

Overview:
- Upstream driver of the hash-clock reconfiguration stage: accepts host frequency commands (code 1..96) and steps the SHA PLL toward the target in bounded increments.
- Drives the level `go_reconfig` / `reqstd_frequency` handshake, confirms each step via `reconfig_ok`, retries on timeout, tracks the applied code.
- Runs in the 25 MHz UART/scan clock domain.

Parameters:
- MAX_CODE, 96, highest legal frequency code; 0 is always illegal.
- STEP, 4, maximum code change per reconfiguration.
- SETTLE_CYC, 25000, dwell cycles after each confirmed step (1 ms at 25 MHz).
- TIMEOUT_CYC, 250000, cycles from request to `reconfig_ok` before the attempt fails.
- MAX_RETRY, 3, re-attempts of one step before error.

Ports:
- clk, input, 1, 25 MHz clock (same clock as the reconfiguration stage).
- areset, input, 1, asynchronous active-high reset.
- cmd_valid, input, 1, host command strobe.
- cmd_freq, input, 8, requested target code.
- cmd_ready, output, 1, high in IDLE/SETTLE/ERROR; a command is accepted when cmd_valid & cmd_ready.
- host_break, input, 1, host break level.
- busy, input, 1, reconfiguration stage busy.
- reconfig_ok, input, 1, one-cycle success pulse, arrives while busy is still high.
- go_reconfig, output, 1, reconfiguration request level.
- reqstd_frequency, output, 8, code for the current step.
- cur_freq, output, 8, last successfully applied code.
- ramp_active, output, 1, high whenever target != cur_freq or a step is in flight.
- err_range, output, 1, one-cycle pulse when a command is rejected.
- err_timeout, output, 1, sticky flag when retries are exhausted.

Behaviour:
- Reset values: go_reconfig=0, reqstd_frequency=1, cur_freq=1, target=1, ramp_active=0, err_range=0, err_timeout=0, cmd_ready=1, state=IDLE, counters=0.
- Command acceptance:
  - Accepted only when cmd_ready.
  - cmd_freq==0 or >MAX_CODE: pulse err_range for 1 cycle; target unchanged.
  - Otherwise target<=cmd_freq and err_timeout cleared.
  - A command accepted in SETTLE replaces the target; the dwell still completes.
- Step calculation (9-bit signed arithmetic, no wrap):
  - target>cur: next=min(cur+STEP, target).
  - target<cur: next=max(cur-STEP, target).
- States:
  - IDLE: if target!=cur_freq go CALC.
  - CALC (1 cycle): reqstd_frequency<=next; retry count=0; go REQ.
  - REQ: go_reconfig=1; load timeout counter; go WAIT_ACK.
  - WAIT_ACK: hold go_reconfig until busy=1, then go_reconfig<=0 and go WAIT_OK. reqstd_frequency must stay stable from REQ through WAIT_OK.
  - WAIT_OK: on reconfig_ok, cur_freq<=reqstd_frequency and go WAIT_IDLE.
  - WAIT_IDLE: wait busy=0; load settle counter; go SETTLE.
  - SETTLE: count SETTLE_CYC; then IDLE. If target==cur_freq, ramp_active falls on that cycle.
  - ERROR: go_reconfig=0; stay until an accepted legal command (→IDLE) or host_break edge.
- Timeout:
  - Counter runs in REQ/WAIT_ACK/WAIT_OK. On expiry, go_reconfig<=0, wait busy=0, retry++.
  - retry<MAX_RETRY: back to REQ with the same code.
  - Else err_timeout<=1, cur_freq unchanged, go ERROR.
- host_break:
  - Edge-detected; a held level is ignored after the first cycle.
  - A rising edge sets target=1 from any state.
  - An in-flight step (WAIT_ACK/WAIT_OK/WAIT_IDLE) completes normally first.
  - In ERROR the edge clears err_timeout and goes IDLE.
- Simultaneous events:
  - host_break edge and accepted command in the same cycle: host_break wins, command is dropped with no err_range.
  - reconfig_ok and timeout expiry in the same cycle: reconfig_ok wins.
- Latency: accepted command → go_reconfig high = 3 cycles from IDLE.
- areset mid-ramp: immediate return to reset values. The downstream stage is assumed reset by the same source.

Optional Feature:
- FREQ_DOWN_DIRECT_EN defined: when target<cur_freq, next=target (single-step descent); ascents still use STEP.
- Undefined: descents also step by STEP.

Test Plan:
- Reset, cmd 20, model acks after 10 cycles → reqstd_frequency sequence 5,9,13,17,20; cur_freq=20; ramp_active falls after last SETTLE.
- cmd 0 then cmd 97 → two err_range pulses; target/cur stay 1; no go_reconfig.
- Model never returns reconfig_ok (TIMEOUT_CYC=100, MAX_RETRY=3) → 4 requests for the same code, then err_timeout=1, state ERROR, cur_freq unchanged; next cmd 8 clears it.
- At cur=20, host_break rises mid WAIT_OK of step 24 → step completes (cur=24), then descent 20,16,...,4,1 (direct to 1 when FREQ_DOWN_DIRECT_EN).
- Same-cycle host_break edge and cmd 50 → target=1, no err_range.
- areset asserted during WAIT_ACK → go_reconfig low asynchronously, cur_freq=1, cmd_ready=1.
